// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill path.
package cache_pkg;

   typedef enum logic {
      IDLE,
      FILL
   } fill_state_t;

   localparam int unsigned BLOCK_WORDS = 8;
   localparam int unsigned WORD_BYTES  = 2;

   // Clears the block-offset bits of a byte address.
   function automatic logic [31:0] block_base(input logic [31:0] addr,
                                              input int unsigned off_bits);
      return addr & ~((32'd1 << off_bits) - 32'd1);
   endfunction

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous reset/clear and increment enable.
module fill_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         count_q <= '0;
      end else if (inc_i) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: issues one read per block word, writes returned words
// into the data array and the tag with the last word.
module cache_fill_fsm #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   output logic              fill_busy,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_address,
   input  logic              mem_data_valid,
   input  logic [DATA_W-1:0] mem_data,
   output logic              write_data_array,
   output logic [ADDR_W-1:0] fill_address,
   output logic [DATA_W-1:0] fill_data,
   output logic              write_tag_array
);

   import cache_pkg::*;

   localparam int unsigned WB  = $clog2(BLOCK_WORDS);
   localparam int unsigned OFF = $clog2(BLOCK_WORDS * WORD_BYTES);
   localparam int unsigned BB  = OFF - WB;
   localparam int unsigned IW  = WB + 1;

   fill_state_t       state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [IW-1:0]     iss_q;
   logic [WB-1:0]     rcv_q;
   logic              cnt_clr, iss_inc, rcv_inc;

   fill_counter #(.W(IW)) u_iss (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (cnt_clr),
      .inc_i   (iss_inc),
      .count_o (iss_q)
   );

   fill_counter #(.W(WB)) u_rcv (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (cnt_clr),
      .inc_i   (rcv_inc),
      .count_o (rcv_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
      end
   end

   // Word offsets are OR-ed into a base with cleared offset bits, so the
   // address can never carry into the tag field.
   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      cnt_clr          = 1'b0;
      iss_inc          = 1'b0;
      rcv_inc          = 1'b0;
      fill_busy        = 1'b0;
      mem_read         = 1'b0;
      mem_address      = '0;
      write_data_array = 1'b0;
      fill_address     = '0;
      fill_data        = '0;
      write_tag_array  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (miss_detected) begin
               state_d = FILL;
               base_d  = ADDR_W'(block_base(32'(miss_address), OFF));
               cnt_clr = 1'b1;
            end
         end
         FILL: begin
            fill_busy = 1'b1;
            if (iss_q != IW'(BLOCK_WORDS)) begin
               mem_read    = 1'b1;
               mem_address = base_q | ADDR_W'({iss_q[WB-1:0], {BB{1'b0}}});
               iss_inc     = 1'b1;
            end
            if (mem_data_valid) begin
               write_data_array = 1'b1;
               fill_address     = base_q | ADDR_W'({rcv_q, {BB{1'b0}}});
               fill_data        = mem_data;
               rcv_inc          = 1'b1;
               if (rcv_q == WB'(BLOCK_WORDS - 1)) begin
                  write_tag_array = 1'b1;
                  state_d         = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed self-checking bench for cache_fill_fsm (8-word blocks, L=4 memory).
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst, miss_detected, mem_data_valid;
   logic [15:0] miss_address, mem_data;
   logic        fill_busy, mem_read, write_data_array, write_tag_array;
   logic [15:0] mem_address, fill_address, fill_data;

   int unsigned total  = 0;
   int unsigned passed = 0;
   int unsigned wda_seen, wtag_seen;
   int unsigned vcyc [8];

   always #5 clk = ~clk;

   cache_fill_fsm #(
      .ADDR_W      (16),
      .DATA_W      (16),
      .BLOCK_WORDS (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .miss_detected    (miss_detected),
      .miss_address     (miss_address),
      .fill_busy        (fill_busy),
      .mem_read         (mem_read),
      .mem_address      (mem_address),
      .mem_data_valid   (mem_data_valid),
      .mem_data         (mem_data),
      .write_data_array (write_data_array),
      .fill_address     (fill_address),
      .fill_data        (fill_data),
      .write_tag_array  (write_tag_array)
   );

   typedef struct {
      logic        rst;
      logic        miss;
      logic [15:0] addr;
      logic        dv;
      logic [15:0] data;
      logic        busy;
      logic        rd;
      logic [15:0] maddr;
      logic        wda;
      logic [15:0] faddr;
      logic [15:0] fdata;
      logic        wtag;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic chk_outs(input string tag, input logic busy, input logic rd,
                           input logic [15:0] maddr, input logic wda,
                           input logic [15:0] faddr, input logic [15:0] fdata,
                           input logic wtag);
      chk({tag, " busy"},  16'(fill_busy),        16'(busy));
      chk({tag, " rd"},    16'(mem_read),         16'(rd));
      chk({tag, " maddr"}, mem_address,           maddr);
      chk({tag, " wda"},   16'(write_data_array), 16'(wda));
      chk({tag, " faddr"}, fill_address,          faddr);
      chk({tag, " fdata"}, fill_data,             fdata);
      chk({tag, " wtag"},  16'(write_tag_array),  16'(wtag));
      if (write_data_array === 1'b1) wda_seen++;
      if (write_tag_array === 1'b1) wtag_seen++;
   endtask

   // One fill from a miss in cycle 0; valids arrive in the cycles listed in vcyc.
   task automatic run_fill(input string nm, input logic [15:0] addr, input logic [15:0] base,
                           input int unsigned rst_cyc, input bit b2b);
      int unsigned k = 0;
      int unsigned last;
      int unsigned exp_w = 0;
      bit          done = 1'b0;
      bit          killed = 1'b0;
      logic        v;
      logic [15:0] d;
      wda_seen  = 0;
      wtag_seen = 0;
      @(negedge clk);
      rst = 1'b0; miss_detected = 1'b1; miss_address = addr; mem_data_valid = 1'b0;
      #1;
      chk_outs({nm, " c0"}, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
      last = b2b ? vcyc[7] + 1 : vcyc[7] + 3;
      for (int unsigned c = 1; c <= last; c++) begin
         @(negedge clk);
         v = (k < 8) && (c == vcyc[k]);
         d = 16'($urandom);
         rst = (c == rst_cyc);
         mem_data_valid = v;
         mem_data = d;
         if (!done && !killed) begin
            miss_detected = 1'b1; miss_address = addr ^ 16'h5A5A;
         end else if (b2b) begin
            miss_detected = 1'b1; miss_address = 16'h4000; mem_data_valid = 1'b1;
         end else begin
            miss_detected = 1'b0; miss_address = 16'($urandom);
         end
         #1;
         if (!done && !killed)
            chk_outs($sformatf("%s c%0d", nm, c), 1'b1, c <= 8,
                     (c <= 8) ? base + 16'(2 * (c - 1)) : 16'h0,
                     v, v ? base + 16'(2 * k) : 16'h0, v ? d : 16'h0, v && (k == 7));
         else
            chk_outs($sformatf("%s c%0d", nm, c), 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
         if (v) k++;
         if (!killed && !done && v && k == 8) done = 1'b1;
         if (rst) killed = 1'b1;
      end
      for (int i = 0; i < 8; i++)
         if (rst_cyc == 0 || vcyc[i] < rst_cyc) exp_w++;
      chk({nm, " writes"}, 16'(wda_seen), 16'(exp_w));
      chk({nm, " tags"}, 16'(wtag_seen), (rst_cyc == 0) ? 16'h1 : 16'h0);
   endtask

   task automatic set_vcyc_plain();
      for (int i = 0; i < 8; i++) vcyc[i] = 5 + i;
   endtask

   initial begin
      vec_t r;
      rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
      mem_data_valid = 1'b0; mem_data = '0;
      repeat (2) @(posedge clk);

      // Reset rows, then miss at 0x1236 with L=4 (valids cycles 5..12).
      for (int i = 0; i < 3; i++) begin
         r = '{rst: 1'b1, miss: 1'b1, addr: 16'($urandom), dv: 1'b1, data: 16'($urandom),
               busy: 1'b0, rd: 1'b0, maddr: 16'h0, wda: 1'b0, faddr: 16'h0, fdata: 16'h0,
               wtag: 1'b0};
         tbl.push_back(r);
      end
      for (int c = 0; c <= 14; c++) begin
         r.rst   = 1'b0;
         r.miss  = (c <= 12);
         r.addr  = 16'h1236;
         r.dv    = (c >= 5 && c <= 12);
         r.data  = r.dv ? 16'hA000 + 16'(c - 5) : 16'h5555;
         r.busy  = (c >= 1 && c <= 12);
         r.rd    = (c >= 1 && c <= 8);
         r.maddr = r.rd ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0;
         r.wda   = r.dv;
         r.faddr = r.dv ? 16'h1230 + 16'(2 * (c - 5)) : 16'h0;
         r.fdata = r.dv ? r.data : 16'h0;
         r.wtag  = (c == 12);
         tbl.push_back(r);
      end
      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rst; miss_detected = tbl[i].miss; miss_address = tbl[i].addr;
         mem_data_valid = tbl[i].dv; mem_data = tbl[i].data;
         #1;
         chk_outs($sformatf("tbl%0d", i), tbl[i].busy, tbl[i].rd, tbl[i].maddr, tbl[i].wda,
                  tbl[i].faddr, tbl[i].fdata, tbl[i].wtag);
      end

      // Top-of-address-space block: must end at 0xFFFE, never wrap.
      set_vcyc_plain();
      run_fill("edge", 16'hFFF2, 16'hFFF0, 0, 1'b0);

      // Reset in the cycle after the 3rd valid; later valids must be ignored.
      vcyc = '{5, 6, 7, 11, 12, 13, 14, 15};
      run_fill("rst", 16'h2468, 16'h2460, 8, 1'b0);

      // Random 0..5 cycle gaps between valids.
      vcyc[0] = 5 + $urandom_range(5, 0);
      for (int i = 1; i < 8; i++) vcyc[i] = vcyc[i-1] + 1 + $urandom_range(5, 0);
      run_fill("gap", 16'h7A1C, 16'h7A10, 0, 1'b0);

      // Miss held into IDLE with a new address, plus a spurious valid in IDLE.
      set_vcyc_plain();
      run_fill("b2b", 16'h1236, 16'h1230, 0, 1'b1);
      @(negedge clk);
      miss_detected = 1'b0; mem_data_valid = 1'b0;
      #1;
      chk_outs("b2b c14", 1'b1, 1'b1, 16'h4000, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      #1;
      chk_outs("b2b c15", 1'b1, 1'b1, 16'h4002, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_outs("final", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
      $fatal(1);
   end

endmodule
